wave_capture: RTL and testbench

Writer side of the double-buffered 512-entry waveform sample RAM whose read side is owned by the wave display. Watches the incoming audio sample stream and arms on a positive-going zero crossing. Writes 256 consecutive 8-bit offset-binary samples into the RAM half not currently displayed, then waits for the display's vertical-blank idle indication and flips `read_index` so the display reads the fresh buffer.

---
 rtl/wave_capture.sv | 105 ++++++++++
 tb/tb_wave_capture.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_capture.sv
// Writer side of the double-buffered waveform RAM: arms on a positive-going zero
// crossing, stores 256 offset-binary samples into the hidden half, then swaps halves in vblank.
module wave_capture #(
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                new_sample_ready,
    input  logic [SAMPLE_W-1:0] new_sample_in,
    input  logic                wave_display_idle,
    output logic                write_enable,
    output logic [8:0]          write_address,
    output logic [7:0]          write_sample,
    output logic                read_index
);

    typedef enum logic [1:0] {
        S_ARMED  = 2'd0,
        S_ACTIVE = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        prev_sign_q, prev_sign_d;
    logic        ridx_q, ridx_d;
    logic        we_q, we_d;
    logic [8:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    logic        trigger;
    logic        store;
    logic        flip;
    logic [7:0]  converted;

    // Only the sign of the previous sample matters for crossing detection.
    assign trigger   = (state_q == S_ARMED) && new_sample_ready
                       && prev_sign_q && !new_sample_in[SAMPLE_W-1];
    assign store     = new_sample_ready && (trigger || (state_q == S_ACTIVE));
    assign flip      = (state_q == S_WAIT) && wave_display_idle;
    assign converted = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};

    generate
        if (SAMPLE_W > 8) begin : g_low_bits
            logic low_bits_unused;
            assign low_bits_unused = ^new_sample_in[SAMPLE_W-9:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_ARMED;
            cnt_q       <= 8'd0;
            prev_sign_q <= 1'b0;
            ridx_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 9'd0;
            data_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_sign_q <= prev_sign_d;
            ridx_q      <= ridx_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ARMED:  if (trigger) state_d = S_ACTIVE;
            S_ACTIVE: if (new_sample_ready && (cnt_q == 8'hFF)) state_d = S_WAIT;
            S_WAIT:   if (wave_display_idle) state_d = S_ARMED;
            default:  state_d = S_ARMED;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        prev_sign_d = new_sample_ready ? new_sample_in[SAMPLE_W-1] : prev_sign_q;
        ridx_d      = ridx_q;
        we_d        = store;
        addr_d      = addr_q;
        data_d      = data_q;

        if (store) begin
            addr_d = {~ridx_q, trigger ? 8'd0 : cnt_q};
            data_d = converted;
            cnt_d  = trigger ? 8'd1 : cnt_q + 8'd1;
        end

        if (flip) begin
            ridx_d = ~ridx_q;
            cnt_d  = 8'd0;
        end
    end

    assign write_enable  = we_q;
    assign write_address = addr_q;
    assign write_sample  = data_q;
    assign read_index    = ridx_q;

endmodule

// File: tb/tb_wave_capture.sv
// Scoreboarded bench for wave_capture: a reference model queues expected RAM writes
// as stimulus is driven; a negedge monitor pops and compares each observed write.
module tb_wave_capture;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        new_sample_ready = 1'b0;
    logic [15:0] new_sample_in = 16'd0;
    logic        wave_display_idle = 1'b0;
    logic        write_enable;
    logic [8:0]  write_address;
    logic [7:0]  write_sample;
    logic        read_index;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;

    // Reference model state: 0 armed, 1 active, 2 waiting for vblank.
    int         m_state = 0;
    bit [7:0]   m_cnt = 8'd0;
    bit         m_prev_neg = 1'b0;
    bit         m_ridx = 1'b0;
    logic [16:0] exp_q[$];
    logic [16:0] exp_w;

    wave_capture #(.SAMPLE_W(16)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .wave_display_idle (wave_display_idle),
        .write_enable      (write_enable),
        .write_address     (write_address),
        .write_sample      (write_sample),
        .read_index        (read_index)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_offset(input logic [15:0] v);
        logic [7:0] hi;
        hi = v[15:8];
        return hi + 8'd128;
    endfunction

    always @(negedge clk) begin
        if (write_enable) begin
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: write addr=%h data=%h, required no write", write_address, write_sample);
            end else begin
                exp_w = exp_q.pop_front();
                if ({write_address, write_sample} !== exp_w) begin
                    errors++;
                    $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                             write_address, write_sample, exp_w[16:8], exp_w[7:0]);
                end else begin
                    $display("write addr=%h data=%h ok", write_address, write_sample);
                end
            end
        end
    end

    task automatic drive(input bit rdy, input int s, input bit idle);
        logic [15:0] v;
        int st;
        v = s[15:0];
        @(negedge clk);
        reset_n = 1'b1;
        new_sample_ready = rdy;
        new_sample_in = v;
        wave_display_idle = idle;
        st = m_state;
        if (rdy) begin
            if (st == 0 && m_prev_neg && !v[15]) begin
                exp_q.push_back({~m_ridx, 8'h00, to_offset(v)});
                m_cnt = 8'd1;
                m_state = 1;
            end else if (st == 1) begin
                exp_q.push_back({~m_ridx, m_cnt, to_offset(v)});
                if (m_cnt == 8'hFF) m_state = 2;
                m_cnt = m_cnt + 8'd1;
            end
            m_prev_neg = v[15];
        end
        if (st == 2 && idle) begin
            m_ridx = ~m_ridx;
            m_cnt = 8'd0;
            m_state = 0;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        new_sample_ready = 1'b0;
        wave_display_idle = 1'b0;
        m_state = 0;
        m_cnt = 8'd0;
        m_prev_neg = 1'b0;
        m_ridx = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({write_enable, write_address, write_sample, read_index} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: we=%b addr=%h data=%h ridx=%b, required all 0",
                     write_enable, write_address, write_sample, read_index);
        end
    endtask

    task automatic test_reset();
        do_reset();
        $display("test_reset done");
    endtask

    task automatic test_no_false_trigger();
        int w0;
        w0 = n_writes;
        for (int i = 0; i < 50; i++) drive(1'b1, i * 37, 1'b0);
        for (int i = 0; i < 50; i++) drive(1'b1, -(i * 37 + 1), 1'b0);
        idle_cycles(3);
        checks++;
        if (n_writes - w0 !== 0) begin
            errors++;
            $display("FAIL no_false_trigger: %0d writes, required 0", n_writes - w0);
        end
    endtask

    task automatic test_trigger();
        int w0;
        w0 = n_writes;
        drive(1'b1, -5, 1'b0);
        drive(1'b1, -1, 1'b0);
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 100, 1'b0);
        #1;
        checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h100, 8'h80}) begin
            errors++;
            $display("FAIL trigger_first: we=%b addr=%h data=%h, required 1 100 80",
                     write_enable, write_address, write_sample);
        end
        for (int i = 2; i <= 255; i++) drive(1'b1, i * 100, 1'b0);
        idle_cycles(3);
        checks++;
        if (n_writes - w0 !== 256 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL trigger_count: %0d writes, %0d pending, required 256 and 0", n_writes - w0, exp_q.size());
        end
        w0 = n_writes;
        for (int i = 0; i < 10; i++) drive(1'b1, (i % 2) ? 50 : -50, 1'b0);
        idle_cycles(2);
        checks++;
        if (n_writes - w0 !== 0) begin
            errors++;
            $display("FAIL trigger_after_full: %0d writes, required 0", n_writes - w0);
        end
    endtask

    task automatic test_buffer_swap();
        int w0;
        w0 = n_writes;
        for (int i = 0; i < 100; i++) drive(1'b1, (i % 2) ? 5 : -3, 1'b0);
        idle_cycles(2);
        checks++;
        if (n_writes - w0 !== 0 || read_index !== 1'b0) begin
            errors++;
            $display("FAIL swap_wait: %0d writes ridx=%b, required 0 writes ridx=0", n_writes - w0, read_index);
        end
        drive(1'b0, 0, 1'b1);
        #1;
        checks++;
        if (read_index !== 1'b0) begin
            errors++;
            $display("FAIL swap_early: ridx=%b, required 0", read_index);
        end
        drive(1'b0, 0, 1'b0);
        #1;
        checks++;
        if (read_index !== 1'b1) begin
            errors++;
            $display("FAIL swap_flip: ridx=%b, required 1", read_index);
        end
        w0 = n_writes;
        drive(1'b1, -1, 1'b0);
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 7, 1'b0);
        #1;
        checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h000, 8'h80}) begin
            errors++;
            $display("FAIL swap_first: we=%b addr=%h data=%h, required 1 000 80",
                     write_enable, write_address, write_sample);
        end
        for (int i = 2; i <= 255; i++) drive(1'b1, i * 13, 1'b0);
        idle_cycles(3);
        checks++;
        if (n_writes - w0 !== 256 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL swap_capture: %0d writes, %0d pending, required 256 and 0", n_writes - w0, exp_q.size());
        end
    endtask

    task automatic test_simultaneous();
        int w0;
        w0 = n_writes;
        drive(1'b1, -3, 1'b0);
        drive(1'b1, 4, 1'b1);
        drive(1'b1, 4, 1'b0);
        #1;
        checks++;
        if (read_index !== 1'b0 || write_enable !== 1'b0) begin
            errors++;
            $display("FAIL simul_flip: ridx=%b we=%b, required ridx=0 we=0", read_index, write_enable);
        end
        idle_cycles(3);
        checks++;
        if (n_writes - w0 !== 0) begin
            errors++;
            $display("FAIL simul_no_trigger: %0d writes, required 0", n_writes - w0);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        drive(1'b1, -1, 1'b0);
        for (int i = 0; i < 256; i++) drive(1'b1, i, 1'b0);
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b0);
        w0 = n_writes;
        drive(1'b1, -9, 1'b0);
        for (int i = 0; i < 40; i++) drive(1'b1, i * 3, 1'b0);
        do_reset();
        checks++;
        if (n_writes - w0 !== 40 || read_index !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: %0d writes ridx=%b, required 40 writes ridx=0", n_writes - w0, read_index);
        end
        drive(1'b1, -1, 1'b0);
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 16'h1234, 1'b0);
        #1;
        checks++;
        if ({write_enable, write_address, write_sample} !== {1'b1, 9'h100, 8'h80}) begin
            errors++;
            $display("FAIL reset_restart: we=%b addr=%h data=%h, required 1 100 80",
                     write_enable, write_address, write_sample);
        end
        idle_cycles(2);
    endtask

    task automatic test_conversion();
        do_reset();
        drive(1'b1, -1, 1'b0);
        drive(1'b1, 0, 1'b0);
        drive(1'b1, 32'h8000, 1'b0);
        drive(1'b1, 32'h7FFF, 1'b0);
        #1;
        checks++;
        if (write_sample !== 8'h00 || write_address !== 9'h101) begin
            errors++;
            $display("FAIL conv_min: addr=%h data=%h, required 101 00", write_address, write_sample);
        end
        drive(1'b1, 32'h00FF, 1'b0);
        #1;
        checks++;
        if (write_sample !== 8'hFF || write_address !== 9'h102) begin
            errors++;
            $display("FAIL conv_max: addr=%h data=%h, required 102 ff", write_address, write_sample);
        end
        drive(1'b0, 0, 1'b0);
        #1;
        checks++;
        if (write_sample !== 8'h80 || write_enable !== 1'b1) begin
            errors++;
            $display("FAIL conv_small: we=%b data=%h, required 1 80", write_enable, write_sample);
        end
        drive(1'b0, 0, 1'b0);
        #1;
        checks++;
        if (write_enable !== 1'b0) begin
            errors++;
            $display("FAIL conv_pulse: we=%b, required 0", write_enable);
        end
        idle_cycles(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL conv_pending: %0d writes missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_no_false_trigger();
        test_trigger();
        test_buffer_swap();
        test_simultaneous();
        test_reset_mid();
        test_conversion();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
